// File: rtl/match_scoreboard_if.sv
// Bus between full_game's result outputs, the match scoreboard and the display side.
interface match_scoreboard_if #(
  parameter int unsigned SCORE_W = 3
);
  logic               gameover;
  logic               who;
  logic               game_init;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic [SCORE_W:0]   games_played;
  logic               match_over;
  logic               match_winner;

  modport master (
    output gameover, who,
    input  game_init, score_a, score_b, games_played, match_over, match_winner
  );

  modport slave (
    input  gameover, who,
    output game_init, score_a, score_b, games_played, match_over, match_winner
  );
endinterface

// File: rtl/match_scoreboard.sv
// Best-of match scoreboard: tallies full_game results, re-arms the game between
// rounds and declares a match winner once a player reaches WINS_TO_MATCH.
module match_scoreboard #(
  parameter int unsigned WINS_TO_MATCH = 3,
  parameter int unsigned SCORE_W       = 3,
  parameter int unsigned REARM_DELAY   = 4
) (
  input  logic                clk,
  input  logic                init,
  match_scoreboard_if.slave   bus
);

  localparam int unsigned CNT_W = (REARM_DELAY > 1) ? $clog2(REARM_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(REARM_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WINS_TO_MATCH);

  typedef enum logic [1:0] {
    REARM = 2'd0,
    PLAY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [SCORE_W:0]   played_q, played_d;
  logic               over_q, over_d;
  logic               winner_q, winner_d;
  logic               gameover_q;
  logic               rise;
  logic [SCORE_W-1:0] new_score;

  // Edge register starts at 1 so a gameover held through reset is not a new game.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= REARM;
      cnt_q      <= '0;
      score_a_q  <= '0;
      score_b_q  <= '0;
      played_q   <= '0;
      over_q     <= 1'b0;
      winner_q   <= 1'b0;
      gameover_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score_a_q  <= score_a_d;
      score_b_q  <= score_b_d;
      played_q   <= played_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
      gameover_q <= bus.gameover;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    played_d  = played_q;
    over_d    = over_q;
    winner_d  = winner_q;
    rise      = bus.gameover & ~gameover_q;
    new_score = bus.who ? (score_b_q + SCORE_W'(1)) : (score_a_q + SCORE_W'(1));

    case (state_q)
      REARM: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PLAY: begin
        if (rise) begin
          if (bus.who) begin
            score_b_d = new_score;
          end else begin
            score_a_d = new_score;
          end
          played_d = played_q + (SCORE_W + 1)'(1);
          if (new_score == WIN_SCORE) begin
            state_d  = DONE;
            over_d   = 1'b1;
            winner_d = bus.who;
          end else begin
            state_d = REARM;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = REARM;
      end
    endcase
  end

  assign bus.game_init    = (state_q == REARM);
  assign bus.score_a      = score_a_q;
  assign bus.score_b      = score_b_q;
  assign bus.games_played = played_q;
  assign bus.match_over   = over_q;
  assign bus.match_winner = winner_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Scoreboard bench for match_scoreboard: three configurations driven in parallel,
// expected updates queued by a rule-level model and checked by a negedge monitor.
module tb_match_scoreboard;

  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rs[3];
  logic go[3];
  logic wh[3];

  match_scoreboard_if #(.SCORE_W(SW)) bus0 ();
  match_scoreboard_if #(.SCORE_W(SW)) bus1 ();
  match_scoreboard_if #(.SCORE_W(SW)) bus2 ();

  assign bus0.gameover = go[0];
  assign bus0.who      = wh[0];
  assign bus1.gameover = go[1];
  assign bus1.who      = wh[1];
  assign bus2.gameover = go[2];
  assign bus2.who      = wh[2];

  match_scoreboard #(.WINS_TO_MATCH(3), .SCORE_W(SW), .REARM_DELAY(4))
    u0 (.clk(clk), .init(rs[0]), .bus(bus0));
  match_scoreboard #(.WINS_TO_MATCH(1), .SCORE_W(SW), .REARM_DELAY(1))
    u1 (.clk(clk), .init(rs[1]), .bus(bus1));
  match_scoreboard #(.WINS_TO_MATCH(7), .SCORE_W(SW), .REARM_DELAY(4))
    u2 (.clk(clk), .init(rs[2]), .bus(bus2));

  logic [SW-1:0] o_sa[3], o_sb[3];
  logic [SW:0]   o_gp[3];
  logic          o_ov[3], o_wn[3], o_gi[3];

  assign o_sa[0] = bus0.score_a;  assign o_sb[0] = bus0.score_b;
  assign o_gp[0] = bus0.games_played;
  assign o_ov[0] = bus0.match_over; assign o_wn[0] = bus0.match_winner;
  assign o_gi[0] = bus0.game_init;
  assign o_sa[1] = bus1.score_a;  assign o_sb[1] = bus1.score_b;
  assign o_gp[1] = bus1.games_played;
  assign o_ov[1] = bus1.match_over; assign o_wn[1] = bus1.match_winner;
  assign o_gi[1] = bus1.game_init;
  assign o_sa[2] = bus2.score_a;  assign o_sb[2] = bus2.score_b;
  assign o_gp[2] = bus2.games_played;
  assign o_ov[2] = bus2.match_over; assign o_wn[2] = bus2.match_winner;
  assign o_gi[2] = bus2.game_init;

  typedef struct {
    int sa;
    int sb;
    int gp;
    int ov;
    int wn;
    int stamp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  function automatic int cfg_w(int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_d(int k);
    return (k == 1) ? 1 : 4;
  endfunction

  function void push(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function exp_t qpop(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Rule-level reference: scores, games played, match flag and the cycle from which
  // a new game may be counted (D+1 edges after a reset or a non-winning game).
  int  m_sa[3], m_sb[3], m_gp[3], m_acc[3];
  bit  m_ov[3], m_wn[3], m_prev[3], m_gi[3], m_started[3];
  int  edge_n = 0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_sa[k] = 0; m_sb[k] = 0; m_gp[k] = 0; m_acc[k] = 0;
      m_ov[k] = 0; m_wn[k] = 0; m_prev[k] = 1; m_gi[k] = 0; m_started[k] = 0;
    end
    forever begin
      exp_t e;
      bit   r;
      @(posedge clk);
      edge_n++;
      for (int k = 0; k < 3; k++) begin
        if (rs[k]) begin
          if (m_sa[k] != 0 || m_sb[k] != 0 || m_gp[k] != 0 || m_ov[k] || m_wn[k]) begin
            e = '{0, 0, 0, 0, 0, edge_n};
            push(k, e);
          end
          m_sa[k] = 0; m_sb[k] = 0; m_gp[k] = 0; m_ov[k] = 0; m_wn[k] = 0;
          m_prev[k] = 1;
          m_acc[k] = edge_n + cfg_d(k) + 1;
          m_started[k] = 1;
        end else if (m_started[k]) begin
          r = go[k] && !m_prev[k];
          m_prev[k] = go[k];
          if (r && !m_ov[k] && edge_n >= m_acc[k]) begin
            if (wh[k]) m_sb[k]++;
            else       m_sa[k]++;
            m_gp[k]++;
            if (m_sa[k] == cfg_w(k) || m_sb[k] == cfg_w(k)) begin
              m_ov[k] = 1;
              m_wn[k] = wh[k];
            end else begin
              m_acc[k] = edge_n + cfg_d(k) + 1;
            end
            e = '{m_sa[k], m_sb[k], m_gp[k], int'(m_ov[k]), int'(m_wn[k]), edge_n};
            push(k, e);
          end
        end
        m_gi[k] = m_started[k] && !m_ov[k] && (edge_n + 2 <= m_acc[k]);
      end
    end
  end

  // Directed expectations for instance 0 posted by the stimulus.
  int p_sa, p_sb, p_gp, p_ov, p_wn, p_gi;
  int plan_seq = 0;
  string p_name;
  bit fin = 0;

  // Monitor: every output update must match the head of the queue at the same edge.
  initial begin
    int   seen_seq;
    int   ncyc;
    int   l_sa[3], l_sb[3], l_gp[3], l_ov[3], l_wn[3];
    int   max_b2, ov1_seen, pend;
    exp_t e;
    seen_seq = 0; ncyc = 0; max_b2 = 0; ov1_seen = 0;
    for (int k = 0; k < 3; k++) begin
      l_sa[k] = 0; l_sb[k] = 0; l_gp[k] = 0; l_ov[k] = 0; l_wn[k] = 0;
    end
    forever begin
      @(negedge clk);
      ncyc++;
      for (int k = 0; k < 3; k++) begin
        if (m_started[k]) begin
          chk($sformatf("game_init[%0d]", k), int'(o_gi[k]), int'(m_gi[k]));
          if (int'(o_sa[k]) != l_sa[k] || int'(o_sb[k]) != l_sb[k] ||
              int'(o_gp[k]) != l_gp[k] || int'(o_ov[k]) != l_ov[k] ||
              int'(o_wn[k]) != l_wn[k]) begin
            chk($sformatf("update_expected[%0d]", k), int'(qsize(k) > 0), 1);
            if (qsize(k) > 0) begin
              e = qpop(k);
              chk($sformatf("score_a[%0d]", k), int'(o_sa[k]), e.sa);
              chk($sformatf("score_b[%0d]", k), int'(o_sb[k]), e.sb);
              chk($sformatf("games_played[%0d]", k), int'(o_gp[k]), e.gp);
              chk($sformatf("match_over[%0d]", k), int'(o_ov[k]), e.ov);
              chk($sformatf("match_winner[%0d]", k), int'(o_wn[k]), e.wn);
              chk($sformatf("update_edge[%0d]", k), edge_n, e.stamp);
            end
            l_sa[k] = int'(o_sa[k]); l_sb[k] = int'(o_sb[k]); l_gp[k] = int'(o_gp[k]);
            l_ov[k] = int'(o_ov[k]); l_wn[k] = int'(o_wn[k]);
          end
          pend = 0;
          while (qsize(k) > 0) begin
            e = qpop(k);
            pend++;
          end
          chk($sformatf("missed_updates[%0d]", k), pend, 0);
        end
      end
      if (int'(o_sb[2]) > max_b2) max_b2 = int'(o_sb[2]);
      if (o_ov[1]) ov1_seen++;
      if (plan_seq != seen_seq) begin
        seen_seq = plan_seq;
        chk({p_name, ".score_a"}, int'(o_sa[0]), p_sa);
        chk({p_name, ".score_b"}, int'(o_sb[0]), p_sb);
        chk({p_name, ".games_played"}, int'(o_gp[0]), p_gp);
        chk({p_name, ".match_over"}, int'(o_ov[0]), p_ov);
        chk({p_name, ".match_winner"}, int'(o_wn[0]), p_wn);
        chk({p_name, ".game_init"}, int'(o_gi[0]), p_gi);
      end
      if (fin || ncyc > 5000) begin
        if (!fin) begin
          errors++;
          $display("FAIL timeout: stimulus not done after %0d cycles", ncyc);
        end
        chk("w7_score_b_peak", max_b2, 7);
        chk("w1_match_reached", int'(ov1_seen > 0), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  bit rand_en = 0;
  int tcount  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
    if (rand_en) begin
      if ($urandom_range(2) == 0) go[1] = ~go[1];
      wh[1] = 1'($urandom_range(1));
      rs[1] = ($urandom_range(39) == 0);
      if ($urandom_range(1) == 0) go[2] = ~go[2];
      wh[2] = 1'b1;
      rs[2] = (tcount % 150 == 0);
    end
  endtask

  task automatic wait_n(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse0(bit w);
    go[0] = 1'b0;
    tick();
    go[0] = 1'b1;
    wh[0] = w;
    tick();
  endtask

  task automatic plan(string name, int sa, int sb, int gp, int ov, int wn, int gi);
    p_name = name;
    p_sa = sa; p_sb = sb; p_gp = gp; p_ov = ov; p_wn = wn; p_gi = gi;
    plan_seq++;
  endtask

  initial begin
    bit seq[5];
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      rs[k] = 1'b1; go[k] = 1'b1; wh[k] = 1'b0;
    end
    wait_n(2);
    plan("reset", 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) rs[k] = 1'b0;
    rand_en = 1;
    wait_n(10);
    plan("held_gameover", 0, 0, 0, 0, 0, 0);

    pulse0(1'b1);
    plan("single_b", 0, 1, 1, 0, 0, 1);
    go[0] = 1'b0;
    tick();
    go[0] = 1'b1;
    wait_n(9);
    plan("rise_in_rearm", 0, 1, 1, 0, 0, 0);
    pulse0(1'b0);
    plan("after_fall_rise", 1, 1, 2, 0, 0, 1);
    wait_n(6);

    rs[0] = 1'b1;
    tick();
    rs[0] = 1'b0;
    wait_n(6);
    for (int i = 0; i < 5; i++) begin
      pulse0(seq[i]);
      if (i < 4) wait_n(6);
    end
    plan("match_win", 3, 2, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      wait_n(6);
      pulse0(1'b1);
    end
    plan("frozen", 3, 2, 5, 1, 0, 0);

    rs[0] = 1'b1;
    tick();
    rs[0] = 1'b0;
    wait_n(6);
    for (int i = 0; i < 3; i++) begin
      pulse0(seq[i] ^ (i == 1 ? 1'b0 : 1'b0));
      wait_n(6);
    end
    plan("score_2_1", 2, 1, 3, 0, 0, 0);
    go[0] = 1'b0;
    tick();
    go[0] = 1'b1;
    rs[0] = 1'b1;
    tick();
    plan("reset_beats_rise", 0, 0, 0, 0, 0, 1);
    rs[0] = 1'b0;
    wait_n(6);
    pulse0(1'b1);
    plan("first_after_reset", 0, 1, 1, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) go[0] = ~go[0];
      wh[0] = 1'($urandom_range(1));
      rs[0] = ($urandom_range(59) == 0);
      tick();
    end
    rand_en = 0;
    for (int k = 0; k < 3; k++) begin
      rs[k] = 1'b0; go[k] = 1'b0;
    end
    wait_n(20);
    fin = 1;
  end

endmodule
